idli_io_ctrl_m: RTL and testbench
=================================

# idli_io_ctrl_m

Sequencer and arbiter for a single nibble-serial 16-bit IO register. It shares the register between two requesters: A, the core, and B, the external pin interface. It grants each requester a 4-beat read or write transfer. It tracks the register's rotation phase so that reads always start with nibble 0 at the register output. It sits between both requesters and the IO register's `i_reg_data`/`i_reg_wr_en`/`o_reg_data` ports.

## Interface
- No parameters.
- `i_ctrl_gck` in 1: clock; same clock as the IO register.
- `i_ctrl_rst_n` in 1: reset, asynchronous, active-low.
- `i_a_req` in 1: requester A transfer request; held until the first grant beat.
- `i_a_wr` in 1: A direction (1 = write, 0 = read); stable while `i_a_req` is high.
- `i_a_data` in 4: A write nibble, presented during each write grant beat.
- `o_a_gnt` out 1: A transfer beat active (4 consecutive cycles).
- `o_a_data` out 4: A read nibble; valid when `o_a_gnt` is high and the transfer is a read; 0 otherwise.
- `i_b_req`, `i_b_wr`, `i_b_data`, `o_b_gnt`, `o_b_data`: identical for requester B.
- `o_reg_wr_en` out 1: drives the IO register's write enable.
- `o_reg_data` out 4: drives the IO register's write data.
- `i_reg_data` in 4: the IO register's output nibble.

## Operation
- State machine with three states: IDLE, ALIGN and XFER. A 2-bit beat counter `beat` runs 0..3 in XFER.
- The owner (A/B) and the direction are latched when a transfer is selected.
- Phase counter `ph`, 2 bits:
  - Increments mod 4 on every cycle that is not a write beat.
  - On write beat n, the next value is (n+1) mod 4, so `ph` = 0 in the cycle after a write completes.
  - `ph` = 0 means nibble 0 is at `i_reg_data`.
- Selection happens in IDLE, or on `beat` = 3 of XFER (no bubble between transfers):
  - Candidates are requesters with `req` high.
  - If both are candidates, the arbiter picks one (see Configuration).
  - A selected write goes to XFER on the next cycle.
  - A selected read goes to XFER if `ph` will be 0 on the next cycle; otherwise it goes to ALIGN.
- ALIGN: the controller is committed to the selected read. Other requests wait.
  - Moves to XFER when `ph` will be 0 on the next cycle.
  - If the owner drops `req` while in ALIGN, the controller returns to IDLE and no grant is issued.
- XFER, write: `o_reg_wr_en` = 1 and `o_reg_data` = owner's `i_x_data` for 4 beats. The register then holds {n3,n2,n1,n0}, with n0 written first.
- XFER, read: `o_x_data` = `i_reg_data`. The register's rotation gives nibble order 0,3,2,1 across beats 0..3; the requester reassembles the word.
- `req` is ignored during the owner's own XFER. A requester that still has `req` high on `beat` = 3 is treated as a new request.
- Outside write beats: `o_reg_wr_en` = 0 and `o_reg_data` = 0.
- The non-owner's `gnt` and `data` are always 0.

## Timing
- Reset values: state IDLE, `ph` = 0, `beat` = 0, round-robin pointer = A. All outputs are 0.
- Asynchronous reset mid-transfer aborts it immediately. Register contents are then undefined; the first access after reset is a write.
- Write latency: `req` sampled at cycle t gives grant beats at t+1..t+4.
- Read latency: grant beats start at the first cycle ≥ t+1 with `ph` = 0, so the wait is at most 3 cycles in ALIGN.
- Back-to-back: after any XFER, `ph` = 0 on the following cycle, so both reads and writes follow with zero bubbles.
- `gnt`, `o_reg_wr_en` and the data muxes decode registered state only. The only combinational paths are `i_x_data` to `o_reg_data` and `i_reg_data` to `o_x_data`.

## Configuration
- `IDLI_IO_CTRL_FAIR_EN` defined: round-robin arbitration.
  - On conflict, the pointer chooses the winner.
  - The pointer flips to the other requester whenever a transfer is selected.
- `IDLI_IO_CTRL_FAIR_EN` undefined: fixed priority; A always wins a conflict. The pointer logic is removed.

## Test plan
- Reset, A writes 0x1234 (nibbles 4,3,2,1) from cycle 1 → `o_a_gnt` high cycles 2–5 and `o_reg_wr_en` high cycles 2–5. B then reads → `o_b_gnt` cycles 6–9 with data 4,1,2,3.
- Idle for 2 cycles after a write, then a B read request → 1 cycle of ALIGN, then beats start at `ph` = 0 and return nibble 0 first.
- A and B both request writes in the same cycle, with FAIR_EN defined → A is granted, then B with no bubble. Repeat the conflict → B is granted first. With FAIR_EN undefined, A wins both conflicts.
- B read in ALIGN, B drops `req` → return to IDLE, `o_b_gnt` never asserts. A's pending write is granted on the next cycle.
- `i_ctrl_rst_n` asserted on write beat 2 → all outputs 0 immediately. After release, a write of 0xBEEF followed by a read returns F,B,E,E.
- A holds `req` through `beat` = 3 with B idle → A gets a second transfer on the next cycle (8 continuous grant beats).

Source files
------------

// File: rtl/idli_io_ctrl_m.sv
// Arbiter/sequencer for the shared nibble-serial IO register: 4-beat transfers, read phase alignment.
// Optional build macro IDLI_IO_CTRL_FAIR_EN selects round-robin arbitration; otherwise A has fixed priority.
module idli_io_ctrl_m (
  input  logic       i_ctrl_gck,
  input  logic       i_ctrl_rst_n,
  input  logic       i_a_req,
  input  logic       i_a_wr,
  input  logic [3:0] i_a_data,
  output logic       o_a_gnt,
  output logic [3:0] o_a_data,
  input  logic       i_b_req,
  input  logic       i_b_wr,
  input  logic [3:0] i_b_data,
  output logic       o_b_gnt,
  output logic [3:0] o_b_data,
  output logic       o_reg_wr_en,
  output logic [3:0] o_reg_data,
  input  logic [3:0] i_reg_data
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ALIGN = 2'd1,
    ST_XFER  = 2'd2
  } state_e;

  state_e     state_q, state_d;
  logic [1:0] beat_q, beat_d;
  logic [1:0] ph_q, ph_d;
  logic       owner_q, owner_d;   // 0 = A, 1 = B
  logic       wr_q, wr_d;

  logic xfer;
  logic wr_beat;
  logic can_select;
  logic sel_valid;
  logic sel_b;
  logic sel_wr;
  logic owner_req;

  assign xfer    = (state_q == ST_XFER);
  assign wr_beat = xfer & wr_q;

  // A write beat re-aligns the phase to the beat index; everything else rotates.
  assign ph_d = wr_beat ? (beat_q + 2'd1) : (ph_q + 2'd1);

  assign can_select = (state_q == ST_IDLE) | (xfer & (beat_q == 2'd3));
  assign sel_valid  = i_a_req | i_b_req;
  assign owner_req  = owner_q ? i_b_req : i_a_req;
  assign sel_wr     = sel_b ? i_b_wr : i_a_wr;

`ifdef IDLI_IO_CTRL_FAIR_EN
  logic rr_q, rr_d;   // 0 = A preferred on conflict, 1 = B preferred

  assign sel_b = i_b_req & (~i_a_req | rr_q);
  assign rr_d  = (can_select & sel_valid) ? ~sel_b : rr_q;

  always_ff @(posedge i_ctrl_gck or negedge i_ctrl_rst_n) begin
    if (!i_ctrl_rst_n) begin
      rr_q <= 1'b0;
    end else begin
      rr_q <= rr_d;
    end
  end
`else
  assign sel_b = i_b_req & ~i_a_req;
`endif

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    owner_d = owner_q;
    wr_d    = wr_q;
    case (state_q)
      ST_ALIGN: begin
        if (!owner_req) begin
          state_d = ST_IDLE;
        end else if (ph_d == 2'd0) begin
          state_d = ST_XFER;
          beat_d  = 2'd0;
        end
      end
      ST_XFER: begin
        beat_d = beat_q + 2'd1;
        if (beat_q == 2'd3) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    // Selection overrides the default path so transfers chain without a bubble.
    if (can_select && sel_valid) begin
      owner_d = sel_b;
      wr_d    = sel_wr;
      beat_d  = 2'd0;
      state_d = (sel_wr || (ph_d == 2'd0)) ? ST_XFER : ST_ALIGN;
    end
  end

  always_ff @(posedge i_ctrl_gck or negedge i_ctrl_rst_n) begin
    if (!i_ctrl_rst_n) begin
      state_q <= ST_IDLE;
      beat_q  <= 2'd0;
      ph_q    <= 2'd0;
      owner_q <= 1'b0;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      ph_q    <= ph_d;
      owner_q <= owner_d;
      wr_q    <= wr_d;
    end
  end

  assign o_a_gnt     = xfer & ~owner_q;
  assign o_b_gnt     = xfer & owner_q;
  assign o_reg_wr_en = wr_beat;
  assign o_reg_data  = wr_beat ? (owner_q ? i_b_data : i_a_data) : 4'd0;
  assign o_a_data    = (o_a_gnt & ~wr_q) ? i_reg_data : 4'd0;
  assign o_b_data    = (o_b_gnt & ~wr_q) ? i_reg_data : 4'd0;

endmodule

// File: tb/tb_idli_io_ctrl_m.sv
// Directed bench for idli_io_ctrl_m with a rotating 16-bit IO register model.
module tb_idli_io_ctrl_m;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       a_req, a_wr, b_req, b_wr;
  logic [3:0] a_data, b_data;
  logic       a_gnt, b_gnt, reg_wr_en;
  logic [3:0] a_rdata, b_rdata, reg_wdata, reg_rdata;
  logic [15:0] io_reg = 16'h0000;

  int checks = 0;
  int errors = 0;

  idli_io_ctrl_m dut (
    .i_ctrl_gck   (clk),
    .i_ctrl_rst_n (rst_n),
    .i_a_req      (a_req),
    .i_a_wr       (a_wr),
    .i_a_data     (a_data),
    .o_a_gnt      (a_gnt),
    .o_a_data     (a_rdata),
    .i_b_req      (b_req),
    .i_b_wr       (b_wr),
    .i_b_data     (b_data),
    .o_b_gnt      (b_gnt),
    .o_b_data     (b_rdata),
    .o_reg_wr_en  (reg_wr_en),
    .o_reg_data   (reg_wdata),
    .i_reg_data   (reg_rdata)
  );

  always #5 clk = ~clk;

  // IO register: shifts written nibbles in from the top, otherwise rotates so that
  // nibbles appear at the output in the order 0,3,2,1.
  always @(posedge clk) begin
    if (reg_wr_en) io_reg <= {reg_wdata, io_reg[15:4]};
    else           io_reg <= {io_reg[11:0], io_reg[15:12]};
  end
  assign reg_rdata = io_reg[3:0];

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_a_gnt"}, {3'd0, a_gnt}, 4'd0);
    chk({tag, "_b_gnt"}, {3'd0, b_gnt}, 4'd0);
    chk({tag, "_wr_en"}, {3'd0, reg_wr_en}, 4'd0);
    chk({tag, "_wdata"}, reg_wdata, 4'd0);
    chk({tag, "_a_data"}, a_rdata, 4'd0);
    chk({tag, "_b_data"}, b_rdata, 4'd0);
  endtask

  // Four grant beats; w[4k+:4] is the nibble driven (write) or expected (read) on beat k.
  // Leaves the caller on beat 3 so it can set up the next request.
  task automatic xfer(input string tag, input bit is_b, input bit wr, input logic [15:0] w);
    logic [3:0] nib;
    for (int k = 0; k < 4; k++) begin
      nib = w[4*k +: 4];
      if (is_b) begin
        b_data = wr ? nib : 4'h0;
        a_data = ~nib;
      end else begin
        a_data = wr ? nib : 4'h0;
        b_data = ~nib;
      end
      #1;
      $display("%s beat %0d: a_gnt=%0b b_gnt=%0b wr_en=%0b wdata=%0h a_data=%0h b_data=%0h",
               tag, k, a_gnt, b_gnt, reg_wr_en, reg_wdata, a_rdata, b_rdata);
      chk({tag, "_own_gnt"}, {3'd0, (is_b ? b_gnt : a_gnt)}, 4'd1);
      chk({tag, "_oth_gnt"}, {3'd0, (is_b ? a_gnt : b_gnt)}, 4'd0);
      chk({tag, "_wr_en"}, {3'd0, reg_wr_en}, {3'd0, wr});
      chk({tag, "_wdata"}, reg_wdata, wr ? nib : 4'h0);
      chk({tag, "_own_data"}, is_b ? b_rdata : a_rdata, wr ? 4'h0 : nib);
      chk({tag, "_oth_data"}, is_b ? a_rdata : b_rdata, 4'h0);
      if (k == 0) begin
        if (is_b) b_req = 1'b0;
        else      a_req = 1'b0;
      end
      if (k < 3) step();
    end
  endtask

  initial begin
    rst_n = 1'b0;
    a_req = 1'b0; a_wr = 1'b0; a_data = 4'h0;
    b_req = 1'b0; b_wr = 1'b0; b_data = 4'h0;
    step();
    step();
    #1;
    chk_quiet("reset");
    rst_n = 1'b1;

    // A writes 0x1234, then B reads it back with no bubble.
    a_req = 1'b1; a_wr = 1'b1;
    step();
    xfer("a_wr_1234", 1'b0, 1'b1, 16'h1234);
    b_req = 1'b1; b_wr = 1'b0;
    step();
    xfer("b_rd_1234", 1'b1, 1'b0, 16'h3214);

    // Write 0xABCD, idle, then a read that needs one ALIGN cycle.
    a_req = 1'b1; a_wr = 1'b1;
    step();
    xfer("a_wr_abcd", 1'b0, 1'b1, 16'hABCD);
    step();
    step();
    step();
    b_req = 1'b1; b_wr = 1'b0;
    step();
    #1;
    $display("align: a_gnt=%0b b_gnt=%0b", a_gnt, b_gnt);
    chk_quiet("align");
    step();
    xfer("b_rd_abcd", 1'b1, 1'b0, 16'hCBAD);

    // Two write conflicts back to back.
    a_req = 1'b1; a_wr = 1'b1; b_req = 1'b1; b_wr = 1'b1;
    step();
    xfer("conf1_a", 1'b0, 1'b1, 16'h1111);
    a_req = 1'b1;
    step();
`ifdef IDLI_IO_CTRL_FAIR_EN
    xfer("conf2_b", 1'b1, 1'b1, 16'h2222);
    step();
    xfer("conf2_a", 1'b0, 1'b1, 16'h3333);
`else
    xfer("conf2_a", 1'b0, 1'b1, 16'h3333);
    step();
    xfer("conf2_b", 1'b1, 1'b1, 16'h2222);
`endif

    // B read abandoned in ALIGN; A's pending write goes next.
    step();
    #1;
    chk_quiet("idle_pre_abort");
    b_req = 1'b1; b_wr = 1'b0;
    step();
    #1;
    chk_quiet("abort_align");
    b_req = 1'b0;
    a_req = 1'b1; a_wr = 1'b1;
    step();
    #1;
    chk_quiet("abort_idle");
    step();
    xfer("a_wr_after_abort", 1'b0, 1'b1, 16'h2468);

    // Asynchronous reset on write beat 2.
    a_req = 1'b1; a_wr = 1'b1;
    step();
    a_data = 4'h1;
    step();
    a_data = 4'h2;
    step();
    a_data = 4'h3;
    #1;
    chk("rst_beat2_wr_en", {3'd0, reg_wr_en}, 4'd1);
    rst_n = 1'b0;
    #1;
    $display("reset mid-write: a_gnt=%0b wr_en=%0b wdata=%0h", a_gnt, reg_wr_en, reg_wdata);
    chk_quiet("rst_mid");
    a_req = 1'b0;
    step();
    rst_n = 1'b1;
    a_req = 1'b1; a_wr = 1'b1;
    step();
    xfer("a_wr_beef", 1'b0, 1'b1, 16'hBEEF);
    b_req = 1'b1; b_wr = 1'b0;
    step();
    xfer("b_rd_beef", 1'b1, 1'b0, 16'hEEBF);

    // A keeps requesting: two chained writes then a chained read.
    a_req = 1'b1; a_wr = 1'b1;
    step();
    xfer("a_hold_1", 1'b0, 1'b1, 16'h5678);
    a_req = 1'b1;
    step();
    xfer("a_hold_2", 1'b0, 1'b1, 16'h9ABC);
    a_req = 1'b1; a_wr = 1'b0;
    step();
    xfer("a_rd_9abc", 1'b0, 1'b0, 16'hBA9C);
    step();
    #1;
    chk_quiet("final_idle");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
